ccrf_job_issuer: RTL and testbench
==================================

Name: ccrf_job_issuer

Overview:
Host-side initiator for the CCRF job-request protocol.
- Accepts job commands from a local controller.
- Allocates job IDs and packs each command into the 576-bit incoming_job_requests AXI-stream beat consumed by the CCRF wrapper.
- Consumes 64-bit response_message_queue beats, retires the matching outstanding job, and reports completion.
- Sits between the host/PS control logic and the CCRF wrapper's stream ports.

Parameters:
MAX_OUTSTANDING, 8, maximum jobs issued but not yet retired (1..255)
TIMEOUT_CYCLES, 1000000, watchdog limit in aclk cycles (used only with the optional feature)

Ports:
aclk  in  1  clock; all logic rising-edge
aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_is_config  in  1  1 = scratchpad config message (job_id forced 0); 0 = LDR stack job
cmd_addrs  in  384  six 64-bit addresses; [63:0] output/slot0 … [383:320] input5
cmd_width  in  16  image width
cmd_height  in  16  image height
cmd_count  in  8  image count
cmd_job_id  out  8  ID assigned to the accepted command; valid in the acceptance cycle
incoming_job_requests_V_tvalid  out  1  request beat valid
incoming_job_requests_V_tready  in  1  wrapper ready
incoming_job_requests_V_tdata  out  576  packed request
response_message_queue_V_tvalid  in  1  response valid
response_message_queue_V_tready  out  1  always 1 after reset
response_message_queue_V_tdata  in  64  [7:0] job_id, [15:8] status, rest ignored
done_valid  out  1  one-cycle retire pulse
done_job_id  out  8  retired ID
done_status  out  8  status from response (0 = success)
outstanding_count  out  8  jobs in flight
err_unexpected_resp  out  1  sticky; response ID not outstanding
err_timeout  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset values:
  - All outputs 0, except response_message_queue_V_tready, which is 1 from the first aclk edge after reset release.
  - next_id = 1; outstanding bitmap (256 bits) cleared; FSM = IDLE.
- Packing:
  - tdata[383:0] = cmd_addrs.
  - [463:448] = width; [479:464] = height; [487:480] = count; [519:512] = job_id.
  - All other bits 0.
  - Registered on acceptance.
- FSM:
  - IDLE:
    - cmd_ready = 1 when outstanding_count < MAX_OUTSTANDING and the candidate ID's bitmap bit is clear.
    - Candidate ID = 0 for config commands, next_id for jobs.
    - On accept: latch tdata, set the bitmap bit, increment count, go to SEND.
  - SEND:
    - tvalid = 1; tdata held stable until tready.
    - On tvalid&tready: go to IDLE. Earliest next acceptance is the following cycle, so throughput is 1 beat per 2 cycles.
- ID allocation:
  - next_id increments only on job (non-config) acceptance, 1..255, wrapping 255→1; 0 is never allocated to jobs.
  - If next_id is still outstanding, cmd_ready stays low until it retires; no skipping.
- Response handling, on tvalid (tready = 1):
  - If bitmap[id] is set: clear it, decrement count, pulse done_valid with id/status the next cycle.
  - Otherwise: set err_unexpected_resp; count is unchanged and done_valid is not pulsed.
- Simultaneous accept and retire in one cycle:
  - Count is unchanged net.
  - The bitmap set and clear are to different IDs, since acceptance requires a clear bit.
- Responses may arrive in any order and in any state, including SEND.
- Reset mid-SEND: tvalid drops asynchronously; all in-flight state is discarded.
- Sticky errors clear only on reset.

Optional Feature:
Macro CCRF_JOB_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counts while outstanding_count > 0.
  - It resets to 0 on any valid response, or whenever outstanding_count = 0.
  - On reaching TIMEOUT_CYCLES it sets err_timeout (sticky) and holds.
- Undefined: no counter is built; err_timeout is tied to 0.

Decomposition:
- Shared package ccrf_job_pkg:
  - Request field bit offsets/widths (ADDR_W = 64, JOB_ID_LSB = 512, WIDTH_LSB = 448, HEIGHT_LSB = 464, COUNT_LSB = 480, REQ_W = 576, RESP_W = 64).
  - CONFIG_JOB_ID = 0, STATUS_OK = 0, job_id_t (8-bit).
- Natural sub-module: ccrf_outstanding_tracker, which holds the bitmap and count and handles set/clear/lookup, plus unexpected-response detection.

Test Plan:
1. Reset release, config command with cmd_addrs[127:64] = 1000000 and [191:128] = 100000000, tready = 1 → one beat with [519:512] = 0 and matching fields; cmd_job_id = 0; outstanding_count = 1.
2. Job with addrs 100000/10000/20000/30000/40000/50000, width = 100, height = 100, count = 5, tready low 5 cycles → tdata stable throughout; single beat; job_id = 1.
3. Response tdata = 0x0001 (id 1, status 0) → done_valid for one cycle with done_job_id = 1, done_status = 0; outstanding_count decrements.
4. Response for id 7 never issued → err_unexpected_resp = 1; no done_valid; count unchanged.
5. Issue 8 jobs with MAX_OUTSTANDING = 8 → cmd_ready = 0; a response for job 3 in the same cycle as a new cmd_valid → count stays 8; the next command is accepted.
6. With CCRF_JOB_TIMEOUT_EN and TIMEOUT_CYCLES = 50, one job and no response → err_timeout asserts on the 50th cycle; without the macro it stays 0.

Source files
------------

// File: rtl/ccrf_job_pkg.sv
// rtl/ccrf_job_pkg.sv - shared request/response field layout, IDs and FSM states for the CCRF job issuer
package ccrf_job_pkg;

    localparam int ADDR_W     = 64;
    localparam int N_ADDRS    = 6;
    localparam int ADDRS_W    = ADDR_W * N_ADDRS;
    localparam int WIDTH_LSB  = 448;
    localparam int HEIGHT_LSB = 464;
    localparam int COUNT_LSB  = 480;
    localparam int JOB_ID_LSB = 512;
    localparam int REQ_W      = 576;
    localparam int RESP_W     = 64;

    typedef logic [7:0] job_id_t;

    localparam job_id_t    CONFIG_JOB_ID = 8'd0;
    localparam job_id_t    FIRST_JOB_ID  = 8'd1;
    localparam job_id_t    LAST_JOB_ID   = 8'd255;
    localparam logic [7:0] STATUS_OK     = 8'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } issuer_state_t;

    // Builds one request beat; every bit outside the named fields stays zero.
    function automatic logic [REQ_W-1:0] pack_request(
        input logic [ADDRS_W-1:0] addrs,
        input logic [15:0]        width,
        input logic [15:0]        height,
        input logic [7:0]         count,
        input job_id_t            id
    );
        logic [REQ_W-1:0] v;
        v                      = '0;
        v[ADDRS_W-1:0]         = addrs;
        v[WIDTH_LSB  +: 16]    = width;
        v[HEIGHT_LSB +: 16]    = height;
        v[COUNT_LSB  +: 8]     = count;
        v[JOB_ID_LSB +: 8]     = id;
        return v;
    endfunction

    // Job IDs cycle 1..255; 0 is reserved for config messages.
    function automatic job_id_t next_job_id(input job_id_t id);
        return (id == LAST_JOB_ID) ? FIRST_JOB_ID : id + 8'd1;
    endfunction

endpackage

// File: rtl/ccrf_outstanding_tracker.sv
// rtl/ccrf_outstanding_tracker.sv - in-flight job bitmap, count, retire pulse and unexpected-response flag
module ccrf_outstanding_tracker
    import ccrf_job_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_set_en,
    input  job_id_t    i_set_id,
    input  job_id_t    i_lookup_id,
    output logic       o_lookup_busy,
    input  logic       i_resp_valid,
    input  job_id_t    i_resp_id,
    input  logic [7:0] i_resp_status,
    output logic [7:0] o_count,
    output logic       o_done_valid,
    output job_id_t    o_done_id,
    output logic [7:0] o_done_status,
    output logic       o_err_unexpected
);

    logic [255:0] r_bitmap;
    logic [7:0]   r_count;
    logic         r_done_valid;
    job_id_t      r_done_id;
    logic [7:0]   r_done_status;
    logic         r_err_unexpected;
    logic         w_hit;

    assign w_hit         = i_resp_valid && r_bitmap[i_resp_id];
    assign o_lookup_busy = r_bitmap[i_lookup_id];

    // Bitmap: set and clear never target the same ID because a set needs a clear bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bitmap <= '0;
        end else begin
            if (i_set_en) begin
                r_bitmap[i_set_id] <= 1'b1;
            end
            if (w_hit) begin
                r_bitmap[i_resp_id] <= 1'b0;
            end
        end
    end

    // In-flight count; a simultaneous set and retire leaves it unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 8'd0;
        end else if (i_set_en && !w_hit) begin
            r_count <= r_count + 8'd1;
        end else if (!i_set_en && w_hit) begin
            r_count <= r_count - 8'd1;
        end
    end

    // Retire pulse one cycle after a matching response; sticky flag for strays.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done_valid     <= 1'b0;
            r_done_id        <= CONFIG_JOB_ID;
            r_done_status    <= STATUS_OK;
            r_err_unexpected <= 1'b0;
        end else begin
            r_done_valid <= w_hit;
            if (w_hit) begin
                r_done_id     <= i_resp_id;
                r_done_status <= i_resp_status;
            end
            if (i_resp_valid && !r_bitmap[i_resp_id]) begin
                r_err_unexpected <= 1'b1;
            end
        end
    end

    assign o_count          = r_count;
    assign o_done_valid     = r_done_valid;
    assign o_done_id        = r_done_id;
    assign o_done_status    = r_done_status;
    assign o_err_unexpected = r_err_unexpected;

endmodule

// File: rtl/ccrf_job_issuer.sv
// rtl/ccrf_job_issuer.sv - CCRF job-request initiator; watchdog built only with CCRF_JOB_TIMEOUT_EN
module ccrf_job_issuer
    import ccrf_job_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_is_config,
    input  logic [383:0]       cmd_addrs,
    input  logic [15:0]        cmd_width,
    input  logic [15:0]        cmd_height,
    input  logic [7:0]         cmd_count,
    output logic [7:0]         cmd_job_id,
    output logic               incoming_job_requests_V_tvalid,
    input  logic               incoming_job_requests_V_tready,
    output logic [575:0]       incoming_job_requests_V_tdata,
    input  logic               response_message_queue_V_tvalid,
    output logic               response_message_queue_V_tready,
    input  logic [63:0]        response_message_queue_V_tdata,
    output logic               done_valid,
    output logic [7:0]         done_job_id,
    output logic [7:0]         done_status,
    output logic [7:0]         outstanding_count,
    output logic               err_unexpected_resp,
    output logic               err_timeout
);

    issuer_state_t     r_state;
    issuer_state_t     w_state_next;
    logic              r_active;
    job_id_t           r_next_id;
    logic [REQ_W-1:0]  r_req;

    job_id_t           w_cand_id;
    logic              w_cand_busy;
    logic              w_room;
    logic              w_cmd_ready;
    logic              w_req_valid;
    logic              w_accept;
    logic              w_resp_fire;
    logic [RESP_W-1:16] w_unused_resp_hi;

    assign w_cand_id        = cmd_is_config ? CONFIG_JOB_ID : r_next_id;
    assign w_room           = outstanding_count < 8'(MAX_OUTSTANDING);
    assign w_accept         = cmd_valid && w_cmd_ready;
    assign w_resp_fire      = response_message_queue_V_tvalid && r_active;
    assign w_unused_resp_hi = response_message_queue_V_tdata[RESP_W-1:16];

    // Next-state and handshake outputs: accept in IDLE, hold the beat in SEND.
    always_comb begin
        w_state_next = r_state;
        w_cmd_ready  = 1'b0;
        w_req_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = r_active && w_room && !w_cand_busy;
                if (cmd_valid && w_cmd_ready) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                w_req_valid = 1'b1;
                if (incoming_job_requests_V_tready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register; reset drops tvalid immediately.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Goes high on the first edge after reset release and gates all handshakes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // Job ID allocator: advances only when a non-config command is taken.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_next_id <= FIRST_JOB_ID;
        end else if (w_accept && !cmd_is_config) begin
            r_next_id <= next_job_id(r_next_id);
        end
    end

    // Request beat captured at acceptance and held until the wrapper takes it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_req <= '0;
        end else if (w_accept) begin
            r_req <= pack_request(cmd_addrs, cmd_width, cmd_height, cmd_count, w_cand_id);
        end
    end

    ccrf_outstanding_tracker u_tracker (
        .i_clk            (aclk),
        .i_rst_n          (aresetn),
        .i_set_en         (w_accept),
        .i_set_id         (w_cand_id),
        .i_lookup_id      (w_cand_id),
        .o_lookup_busy    (w_cand_busy),
        .i_resp_valid     (w_resp_fire),
        .i_resp_id        (response_message_queue_V_tdata[7:0]),
        .i_resp_status    (response_message_queue_V_tdata[15:8]),
        .o_count          (outstanding_count),
        .o_done_valid     (done_valid),
        .o_done_id        (done_job_id),
        .o_done_status    (done_status),
        .o_err_unexpected (err_unexpected_resp)
    );

    assign cmd_ready                       = w_cmd_ready;
    assign cmd_job_id                      = w_cmd_ready ? w_cand_id : CONFIG_JOB_ID;
    assign incoming_job_requests_V_tvalid  = w_req_valid;
    assign incoming_job_requests_V_tdata   = r_req;
    assign response_message_queue_V_tready = r_active;

`ifdef CCRF_JOB_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    logic        r_err_timeout;

    // Watchdog: counts response-free cycles while work is in flight, saturates at the limit.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else if (w_resp_fire || outstanding_count == 8'd0) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != 32'(TIMEOUT_CYCLES)) begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
            if (r_wd_cnt + 32'd1 == 32'(TIMEOUT_CYCLES)) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ccrf_job_issuer.sv
// tb/tb_ccrf_job_issuer.sv - randomized self-checking bench for ccrf_job_issuer
module tb_ccrf_job_issuer;

    localparam int MAX_OUT = 8;
    localparam int TMO     = 50;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_is_config = 1'b0;
    logic [383:0] cmd_addrs = '0;
    logic [15:0]  cmd_width = '0;
    logic [15:0]  cmd_height = '0;
    logic [7:0]   cmd_count = '0;
    logic [7:0]   cmd_job_id;
    logic         incoming_job_requests_V_tvalid;
    logic         incoming_job_requests_V_tready = 1'b1;
    logic [575:0] incoming_job_requests_V_tdata;
    logic         response_message_queue_V_tvalid = 1'b0;
    logic         response_message_queue_V_tready;
    logic [63:0]  response_message_queue_V_tdata = '0;
    logic         done_valid;
    logic [7:0]   done_job_id;
    logic [7:0]   done_status;
    logic [7:0]   outstanding_count;
    logic         err_unexpected_resp;
    logic         err_timeout;

    int total = 0;
    int bad   = 0;

    bit m_busy [256];
    int m_count;
    int m_next;
    bit m_err;

    ccrf_job_issuer #(.MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(TMO)) dut (
        .aclk                            (aclk),
        .aresetn                         (aresetn),
        .cmd_valid                       (cmd_valid),
        .cmd_ready                       (cmd_ready),
        .cmd_is_config                   (cmd_is_config),
        .cmd_addrs                       (cmd_addrs),
        .cmd_width                       (cmd_width),
        .cmd_height                      (cmd_height),
        .cmd_count                       (cmd_count),
        .cmd_job_id                      (cmd_job_id),
        .incoming_job_requests_V_tvalid  (incoming_job_requests_V_tvalid),
        .incoming_job_requests_V_tready  (incoming_job_requests_V_tready),
        .incoming_job_requests_V_tdata   (incoming_job_requests_V_tdata),
        .response_message_queue_V_tvalid (response_message_queue_V_tvalid),
        .response_message_queue_V_tready (response_message_queue_V_tready),
        .response_message_queue_V_tdata  (response_message_queue_V_tdata),
        .done_valid                      (done_valid),
        .done_job_id                     (done_job_id),
        .done_status                     (done_status),
        .outstanding_count               (outstanding_count),
        .err_unexpected_resp             (err_unexpected_resp),
        .err_timeout                     (err_timeout)
    );

    always #5 aclk = ~aclk;

    function automatic void m_reset();
        for (int i = 0; i < 256; i++) m_busy[i] = 1'b0;
        m_count = 0;
        m_next  = 1;
        m_err   = 1'b0;
    endfunction

    function automatic int m_cand(input bit cfg);
        return cfg ? 0 : m_next;
    endfunction

    function automatic void m_accept(input bit cfg);
        int id;
        id = m_cand(cfg);
        m_busy[id] = 1'b1;
        m_count++;
        if (!cfg) m_next = (m_next == 255) ? 1 : m_next + 1;
    endfunction

    function automatic bit m_retire(input int id);
        if (m_busy[id]) begin
            m_busy[id] = 1'b0;
            m_count--;
            return 1'b1;
        end
        m_err = 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [575:0] m_pack(input logic [383:0] a, input logic [15:0] w,
                                            input logic [15:0] h, input logic [7:0] c, input int id);
        logic [575:0] v;
        v = '0;
        v[383:0]   = a;
        v[463:448] = w;
        v[479:464] = h;
        v[487:480] = c;
        v[519:512] = id[7:0];
        return v;
    endfunction

    function automatic logic [383:0] rand_addrs();
        logic [383:0] a;
        for (int i = 0; i < 12; i++) a[i*32 +: 32] = $urandom;
        return a;
    endfunction

    task automatic drive_cmd(input bit cfg, input logic [383:0] a, input logic [15:0] w,
                             input logic [15:0] h, input logic [7:0] c);
        cmd_is_config = cfg;
        cmd_addrs     = a;
        cmd_width     = w;
        cmd_height    = h;
        cmd_count     = c;
        cmd_valid     = 1'b1;
    endtask

    task automatic wait_accept(output bit ok, output logic [7:0] id);
        ok = 1'b0;
        id = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge aclk);
            if (cmd_ready === 1'b1) begin
                id = cmd_job_id;
                ok = 1'b1;
            end
            @(posedge aclk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send_resp(input int id, input logic [7:0] st);
        response_message_queue_V_tdata  = {48'd0, st, id[7:0]};
        response_message_queue_V_tvalid = 1'b1;
        @(posedge aclk); #1;
        response_message_queue_V_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        incoming_job_requests_V_tready = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        total++;
        if ({cmd_ready, incoming_job_requests_V_tvalid, response_message_queue_V_tready,
             done_valid, err_unexpected_resp, err_timeout} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000", {cmd_ready, incoming_job_requests_V_tvalid,
                     response_message_queue_V_tready, done_valid, err_unexpected_resp, err_timeout});
        end
        total++;
        if ({outstanding_count, done_job_id, done_status, cmd_job_id} !== 32'd0 ||
            incoming_job_requests_V_tdata !== 576'd0) begin
            bad++;
            $display("FAIL reset_values count=%0d done_id=%0d status=%0d job_id=%0d want all 0",
                     outstanding_count, done_job_id, done_status, cmd_job_id);
        end
        #1 aresetn = 1'b1;
        #1;
        total++;
        if (response_message_queue_V_tready !== 1'b0) begin
            bad++;
            $display("FAIL resp_tready_before_edge got=%b want=0", response_message_queue_V_tready);
        end
        @(posedge aclk); #1;
        m_reset();
        total++;
        if (response_message_queue_V_tready !== 1'b1 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_edge resp_tready=%b cmd_ready=%b want 1 1",
                     response_message_queue_V_tready, cmd_ready);
        end
    endtask

    task automatic test_config();
        logic [383:0] a;
        logic [575:0] exp;
        bit ok;
        logic [7:0] id;
        a = '0;
        a[127:64]  = 64'd1000000;
        a[191:128] = 64'd100000000;
        incoming_job_requests_V_tready = 1'b1;
        drive_cmd(1'b1, a, 16'd0, 16'd0, 8'd0);
        wait_accept(ok, id);
        total++;
        if (!ok || id !== 8'd0) begin
            bad++;
            $display("FAIL config_accept ok=%0d job_id=%0d want ok=1 job_id=0", ok, id);
        end
        m_accept(1'b1);
        exp = m_pack(a, 16'd0, 16'd0, 8'd0, 0);
        @(negedge aclk);
        total++;
        if (incoming_job_requests_V_tvalid !== 1'b1 || incoming_job_requests_V_tdata !== exp) begin
            bad++;
            $display("FAIL config_beat tvalid=%b tdata=%h want tvalid=1 tdata=%h",
                     incoming_job_requests_V_tvalid, incoming_job_requests_V_tdata, exp);
        end
        total++;
        if (outstanding_count !== 8'd1) begin
            bad++;
            $display("FAIL config_count got=%0d want=1", outstanding_count);
        end
        @(posedge aclk); #1;
        @(negedge aclk);
        total++;
        if (incoming_job_requests_V_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL config_single_beat tvalid=%b want=0", incoming_job_requests_V_tvalid);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_backpressure();
        logic [383:0] a;
        logic [575:0] exp;
        bit ok;
        bit stable;
        logic [7:0] id;
        int exp_id;
        a = {64'd50000, 64'd40000, 64'd30000, 64'd20000, 64'd10000, 64'd100000};
        incoming_job_requests_V_tready = 1'b0;
        exp_id = m_cand(1'b0);
        drive_cmd(1'b0, a, 16'd100, 16'd100, 8'd5);
        wait_accept(ok, id);
        total++;
        if (!ok || id !== 8'd1 || id !== exp_id[7:0]) begin
            bad++;
            $display("FAIL job_accept ok=%0d job_id=%0d want ok=1 job_id=1", ok, id);
        end
        m_accept(1'b0);
        exp = m_pack(a, 16'd100, 16'd100, 8'd5, exp_id);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (incoming_job_requests_V_tvalid !== 1'b1 || incoming_job_requests_V_tdata !== exp) stable = 1'b0;
            @(posedge aclk); #1;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL stall_stable tvalid=%b tdata=%h want tvalid=1 tdata=%h",
                     incoming_job_requests_V_tvalid, incoming_job_requests_V_tdata, exp);
        end
        incoming_job_requests_V_tready = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        total++;
        if (incoming_job_requests_V_tvalid !== 1'b0 || outstanding_count !== m_count[7:0]) begin
            bad++;
            $display("FAIL stall_release tvalid=%b count=%0d want tvalid=0 count=%0d",
                     incoming_job_requests_V_tvalid, outstanding_count, m_count);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_response();
        bit hit;
        send_resp(1, 8'h00);
        hit = m_retire(1);
        @(negedge aclk);
        total++;
        if (done_valid !== hit || done_job_id !== 8'd1 || done_status !== 8'd0) begin
            bad++;
            $display("FAIL done_pulse valid=%b id=%0d status=%0d want 1 1 0", done_valid, done_job_id, done_status);
        end
        total++;
        if (outstanding_count !== 8'd1) begin
            bad++;
            $display("FAIL retire_count got=%0d want=1", outstanding_count);
        end
        @(posedge aclk); #1;
        @(negedge aclk);
        total++;
        if (done_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle valid=%b want=0", done_valid);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_unexpected();
        bit hit;
        send_resp(7, 8'h55);
        hit = m_retire(7);
        @(negedge aclk);
        total++;
        if (err_unexpected_resp !== 1'b1 || done_valid !== hit || outstanding_count !== 8'd1) begin
            bad++;
            $display("FAIL unexpected err=%b done=%b count=%0d want 1 0 1",
                     err_unexpected_resp, done_valid, outstanding_count);
        end
        repeat (3) @(posedge aclk);
        #1;
        total++;
        if (err_unexpected_resp !== 1'b1) begin
            bad++;
            $display("FAIL unexpected_sticky err=%b want=1", err_unexpected_resp);
        end
    endtask

    task automatic test_full();
        bit ok;
        bit hit;
        logic [7:0] id;
        int exp_id;
        send_resp(0, 8'h00);
        hit = m_retire(0);
        for (int j = 0; j < MAX_OUT; j++) begin
            exp_id = m_cand(1'b0);
            drive_cmd(1'b0, rand_addrs(), 16'($urandom), 16'($urandom), 8'($urandom));
            wait_accept(ok, id);
            m_accept(1'b0);
            total++;
            if (!ok || id !== exp_id[7:0]) begin
                bad++;
                $display("FAIL fill_accept ok=%0d job_id=%0d want ok=1 job_id=%0d", ok, id, exp_id);
            end
        end
        @(posedge aclk); #1;
        drive_cmd(1'b0, rand_addrs(), 16'd1, 16'd2, 8'd3);
        response_message_queue_V_tdata  = 64'h0003;
        response_message_queue_V_tvalid = 1'b1;
        @(negedge aclk);
        total++;
        if (cmd_ready !== 1'b0 || outstanding_count !== 8'(MAX_OUT)) begin
            bad++;
            $display("FAIL full_block ready=%b count=%0d want 0 %0d", cmd_ready, outstanding_count, MAX_OUT);
        end
        @(posedge aclk); #1;
        response_message_queue_V_tvalid = 1'b0;
        hit = m_retire(3);
        exp_id = m_cand(1'b0);
        @(negedge aclk);
        total++;
        if (cmd_ready !== 1'b1 || cmd_job_id !== exp_id[7:0] || done_valid !== hit || done_job_id !== 8'd3) begin
            bad++;
            $display("FAIL full_release ready=%b job_id=%0d done=%b done_id=%0d want 1 %0d 1 3",
                     cmd_ready, cmd_job_id, done_valid, done_job_id, exp_id);
        end
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        m_accept(1'b0);
        @(negedge aclk);
        total++;
        if (outstanding_count !== 8'(MAX_OUT) || m_count != MAX_OUT) begin
            bad++;
            $display("FAIL full_refill count=%0d want=%0d", outstanding_count, MAX_OUT);
        end
        @(posedge aclk); #1;
        for (int k = 0; k < 256; k++) begin
            if (m_busy[k]) begin
                send_resp(k, 8'($urandom));
                hit = m_retire(k);
            end
        end
        @(negedge aclk);
        total++;
        if (outstanding_count !== 8'd0) begin
            bad++;
            $display("FAIL drain_count got=%0d want=0", outstanding_count);
        end
        @(posedge aclk); #1;
        @(posedge aclk); #1;
    endtask

    task automatic test_random();
        bit in_send;
        bit exp_dv;
        int exp_did;
        logic [7:0] exp_dst;
        logic [575:0] exp_beat;
        bit do_cmd;
        bit do_resp;
        bit cfg;
        bit exp_ready;
        bit new_send;
        int rid;
        int base;
        logic [7:0] rst;
        logic [383:0] a;
        logic [15:0] w;
        logic [15:0] h;
        logic [7:0] c;
        in_send  = 1'b0;
        exp_dv   = 1'b0;
        exp_did  = 0;
        exp_dst  = '0;
        exp_beat = '0;
        for (int it = 0; it < 1500; it++) begin
            do_cmd  = $urandom_range(0, 1) == 1;
            cfg     = $urandom_range(0, 7) == 0;
            do_resp = $urandom_range(0, 2) == 0;
            base    = $urandom_range(0, 255);
            rid     = base;
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 256; k++) begin
                    if (m_busy[(base + k) % 256]) begin
                        rid = (base + k) % 256;
                        break;
                    end
                end
            end
            rst = 8'($urandom);
            a = rand_addrs();
            w = 16'($urandom);
            h = 16'($urandom);
            c = 8'($urandom);
            incoming_job_requests_V_tready = $urandom_range(0, 3) != 0;
            cmd_is_config = cfg;
            cmd_addrs = a;
            cmd_width = w;
            cmd_height = h;
            cmd_count = c;
            cmd_valid = do_cmd;
            response_message_queue_V_tdata  = {48'd0, rst, rid[7:0]};
            response_message_queue_V_tvalid = do_resp;
            @(negedge aclk);
            exp_ready = !in_send && m_count < MAX_OUT && !m_busy[m_cand(cfg)];
            total++;
            if (cmd_ready !== exp_ready) begin
                bad++;
                $display("FAIL rnd_ready it=%0d got=%b want=%b", it, cmd_ready, exp_ready);
            end
            if (exp_ready) begin
                total++;
                if (cmd_job_id !== 8'(m_cand(cfg))) begin
                    bad++;
                    $display("FAIL rnd_job_id it=%0d got=%0d want=%0d", it, cmd_job_id, m_cand(cfg));
                end
            end
            total++;
            if (incoming_job_requests_V_tvalid !== in_send ||
                (in_send && incoming_job_requests_V_tdata !== exp_beat)) begin
                bad++;
                $display("FAIL rnd_beat it=%0d tvalid=%b tdata=%h want tvalid=%b tdata=%h", it,
                         incoming_job_requests_V_tvalid, incoming_job_requests_V_tdata, in_send, exp_beat);
            end
            total++;
            if (done_valid !== exp_dv || (exp_dv && (done_job_id !== exp_did[7:0] || done_status !== exp_dst))) begin
                bad++;
                $display("FAIL rnd_done it=%0d valid=%b id=%0d status=%0d want %b %0d %0d", it,
                         done_valid, done_job_id, done_status, exp_dv, exp_did, exp_dst);
            end
            total++;
            if (outstanding_count !== m_count[7:0] || err_unexpected_resp !== m_err) begin
                bad++;
                $display("FAIL rnd_state it=%0d count=%0d err=%b want %0d %b", it,
                         outstanding_count, err_unexpected_resp, m_count, m_err);
            end
            @(posedge aclk);
            new_send = in_send && !incoming_job_requests_V_tready;
            if (do_cmd && exp_ready) begin
                exp_beat = m_pack(a, w, h, c, m_cand(cfg));
                m_accept(cfg);
                new_send = 1'b1;
            end
            exp_dv = 1'b0;
            if (do_resp) begin
                if (m_retire(rid)) begin
                    exp_dv  = 1'b1;
                    exp_did = rid;
                    exp_dst = rst;
                end
            end
            in_send = new_send;
            #1;
            cmd_valid = 1'b0;
            response_message_queue_V_tvalid = 1'b0;
        end
        incoming_job_requests_V_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        logic [7:0] id;
        incoming_job_requests_V_tready = 1'b0;
        drive_cmd(1'b0, rand_addrs(), 16'd7, 16'd8, 8'd9);
        wait_accept(ok, id);
        @(negedge aclk);
        total++;
        if (!ok || incoming_job_requests_V_tvalid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_send ok=%0d tvalid=%b want 1 1", ok, incoming_job_requests_V_tvalid);
        end
        #2 aresetn = 1'b0;
        #1;
        total++;
        if (incoming_job_requests_V_tvalid !== 1'b0 || outstanding_count !== 8'd0) begin
            bad++;
            $display("FAIL async_reset tvalid=%b count=%0d want 0 0", incoming_job_requests_V_tvalid, outstanding_count);
        end
        incoming_job_requests_V_tready = 1'b1;
        @(negedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        m_reset();
        drive_cmd(1'b0, rand_addrs(), 16'd1, 16'd1, 8'd1);
        wait_accept(ok, id);
        m_accept(1'b0);
        total++;
        if (!ok || id !== 8'd1) begin
            bad++;
            $display("FAIL post_reset_id ok=%0d job_id=%0d want ok=1 job_id=1", ok, id);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_timeout();
        bit ok;
        logic [7:0] id;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        m_reset();
        incoming_job_requests_V_tready = 1'b1;
        drive_cmd(1'b0, rand_addrs(), 16'd4, 16'd4, 8'd4);
        wait_accept(ok, id);
        m_accept(1'b0);
        repeat (38) @(posedge aclk);
        @(negedge aclk);
        total++;
        if (err_timeout !== 1'b0 || outstanding_count !== 8'd1) begin
            bad++;
            $display("FAIL timeout_early err=%b count=%0d want 0 1", err_timeout, outstanding_count);
        end
        repeat (16) @(posedge aclk);
        @(negedge aclk);
        total++;
`ifdef CCRF_JOB_TIMEOUT_EN
        if (err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire err=%b want=1", err_timeout);
        end
`else
        if (err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_disabled err=%b want=0", err_timeout);
        end
`endif
    endtask

    initial begin
        m_reset();
        test_reset();
        test_config();
        test_backpressure();
        test_response();
        test_unexpected();
        test_full();
        test_random();
        test_reset_mid_send();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
